// File: rtl/spi_peripheral_pkg.sv
// Shared types and sizing helpers for the SPI peripheral (CPOL=0/CPHA=1).
package spi_peripheral_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Bit counter must hold the value DWIDTH itself, not just DWIDTH-1.
   function automatic int cnt_width(input int dwidth);
      return $clog2(dwidth) + 1;
   endfunction

   // Shortest SCLK high or low phase, in clk cycles, that the oversampler resolves.
   function automatic int min_sclk_phase(input int sync_stages);
      return sync_stages + 1;
   endfunction

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin with rise/fall strobes.
module spi_sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] ff;
   logic              prev;

   // NOTE: INIT matches the pin's idle level so leaving reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ff   <= {STAGES{INIT}};
         prev <= INIT;
      end else begin
         ff   <= {ff[STAGES-2:0], din};
         prev <= ff[STAGES-1];
      end
   end

   assign rise = ff[STAGES-1] & ~prev;
   assign fall = ~ff[STAGES-1] & prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral, mode 1, fully clk-domain: oversampled pins, one-entry TX buffer, RX strobe.
module spi_peripheral
   import spi_peripheral_pkg::*;
#(
   parameter int               DWIDTH      = 8,
   parameter logic [DWIDTH-1:0] DEFAULT_TX = '0,
   parameter int               SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DWIDTH-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DWIDTH-1:0] rx_data,
   output logic              rx_valid,
   output logic              underrun,
   output logic              aborted
);

   localparam int            CW       = cnt_width(DWIDTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DWIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   logic sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_ff;
   logic                   mosi_s;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
      .clk (clk),
      .rst (rst),
      .din (sclk),
      .rise(sclk_rise),
      .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
      .clk (clk),
      .rst (rst),
      .din (ss_n),
      .rise(ss_rise),
      .fall(ss_fall)
   );

   // Same depth as the sclk path, so mosi_s lines up with the detected falling edge.
   always_ff @(posedge clk) begin
      if (rst) mosi_ff <= '0;
      else     mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
   end
   assign mosi_s = mosi_ff[SYNC_STAGES-1];

   state_t              state;
   logic [CW-1:0]       bit_cnt;
   logic [DWIDTH-1:0]   tx_sh;
   logic [DWIDTH-2:0]   rx_sh;
   logic [DWIDTH-1:0]   rx_next;
   logic [DWIDTH-1:0]   buf_q;
   logic                buf_full;
   logic                accept, word_done, load, buf_full_nxt;

   assign rx_next   = {rx_sh, mosi_s};
   assign accept    = tx_valid & tx_ready;
   assign word_done = (state == ACTIVE) & sclk_fall & (bit_cnt == CNT_LAST);
   // A word finishing as ss_n rises ends the frame, so nothing is reloaded for it.
   assign load      = ((state == IDLE) & ss_fall) | (word_done & ~ss_rise);
   // Accept only happens with the buffer empty, so a same-cycle load took DEFAULT_TX.
   assign buf_full_nxt = accept ? 1'b1 : (load ? 1'b0 : buf_full);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= CNT_FULL;
         tx_sh    <= '0;
         rx_sh    <= '0;
         buf_q    <= '0;
         buf_full <= 1'b0;
         tx_ready <= 1'b0;
         miso     <= 1'b0;
         miso_oe  <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         aborted  <= 1'b0;
         buf_full <= buf_full_nxt;
         tx_ready <= ~buf_full_nxt;
         if (accept) buf_q <= tx_data;
         if (load) begin
            tx_sh    <= buf_full ? buf_q : DEFAULT_TX;
            underrun <= ~buf_full;
         end

         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= ACTIVE;
                  bit_cnt <= CNT_FULL;
                  miso_oe <= 1'b1;
               end
            end
            ACTIVE: begin
               if (sclk_rise) begin
                  miso  <= tx_sh[DWIDTH-1];
                  tx_sh <= {tx_sh[DWIDTH-2:0], 1'b0};
               end
               if (sclk_fall) begin
                  rx_sh <= rx_next[DWIDTH-2:0];
                  if (bit_cnt == CNT_LAST) begin
                     rx_data  <= rx_next;
                     rx_valid <= 1'b1;
                     bit_cnt  <= CNT_FULL;
                  end else begin
                     bit_cnt <= bit_cnt - CNT_LAST;
                  end
               end
               if (ss_rise) begin
                  state   <= IDLE;
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
                  bit_cnt <= CNT_FULL;
                  aborted <= (bit_cnt != CNT_FULL) & ~word_done;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a mode-1 master model drives the pins, tasks check each scenario.
module tb_spi_peripheral;
   import spi_peripheral_pkg::*;

   localparam int HALF = min_sclk_phase(2) + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       ss_n = 1'b0;
   logic       mosi = 1'b0;
   logic       miso, miso_oe, tx_ready, rx_valid, underrun, aborted;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic [7:0] rx_data;

   int n_pass = 0;
   int n_total = 0;
   int rx_cnt = 0;
   int un_cnt = 0;
   int ab_cnt = 0;
   logic [7:0] rx_hist[$];

   spi_peripheral #(.DWIDTH(8), .DEFAULT_TX(8'hFF), .SYNC_STAGES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .sclk    (sclk),
      .ss_n    (ss_n),
      .mosi    (mosi),
      .miso    (miso),
      .miso_oe (miso_oe),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .underrun(underrun),
      .aborted (aborted)
   );

   always #5 clk = ~clk;

   // Strobe monitor: a one-cycle pulse is counted exactly once.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rx_cnt++;
         rx_hist.push_back(rx_data);
      end
      if (underrun === 1'b1) un_cnt++;
      if (aborted === 1'b1) ab_cnt++;
   end

   task automatic offer(input logic [7:0] w, input string name);
      bit done = 1'b0;
      tx_data  = w;
      tx_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         if (tx_ready === 1'b1) done = 1'b1;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      n_total++;
      if (!done) $display("FAIL %s_accept: tx_ready never high within 50 cycles", name);
      else n_pass++;
   endtask

   task automatic spi_bits(input logic [7:0] mo, input int nbits, input int half,
                           input bit release_last, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         mosi = mo[7-i];
         repeat (half) @(negedge clk);
         mi[7-i] = miso;
         sclk = 1'b0;
         if (release_last && i == nbits - 1) ss_n = 1'b1;
         repeat (half) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      ss_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sclk = ~sclk;
      end
      @(negedge clk);
      n_total++;
      if ({miso, miso_oe, tx_ready, rx_valid, underrun, aborted} !== 6'b0)
         $display("FAIL reset_outputs: got %b expected 000000",
                  {miso, miso_oe, tx_ready, rx_valid, underrun, aborted});
      else n_pass++;
      n_total++;
      if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data);
      else n_pass++;
      sclk = 1'b0;
      ss_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_total++;
      if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready_after: got %b expected 1", tx_ready);
      else n_pass++;
      n_total++;
      if (rx_cnt + un_cnt + ab_cnt != 0)
         $display("FAIL reset_no_strobes: got %0d strobes expected 0", rx_cnt + un_cnt + ab_cnt);
      else n_pass++;
   endtask

   task automatic test_single_word();
      logic [7:0] mi;
      int r0 = rx_cnt;
      offer(8'hA5, "single");
      n_total++;
      if (tx_ready !== 1'b0) $display("FAIL single_buffer_full: tx_ready got %b expected 0", tx_ready);
      else n_pass++;
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      n_total++;
      if ({tx_ready, miso_oe} !== 2'b11)
         $display("FAIL single_frame_start: {tx_ready,miso_oe} got %b expected 11", {tx_ready, miso_oe});
      else n_pass++;
      spi_bits(8'h3C, 8, HALF, 1'b0, mi);
      n_total++;
      if (mi !== 8'hA5) $display("FAIL single_miso: got %h expected a5", mi);
      else n_pass++;
      n_total++;
      if (rx_cnt != r0 + 1 || rx_data !== 8'h3C)
         $display("FAIL single_rx: pulses %0d data %h expected 1 pulse data 3c", rx_cnt - r0, rx_data);
      else n_pass++;
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
      n_total++;
      if ({miso_oe, miso} !== 2'b00 || ab_cnt != 0)
         $display("FAIL single_release: {oe,miso} %b aborts %0d expected 00 and 0", {miso_oe, miso}, ab_cnt);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] mi;
      int r0 = rx_cnt;
      int u0 = un_cnt;
      int a0 = ab_cnt;
      offer(8'h12, "b2b_first");
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      offer(8'h34, "b2b_second");
      spi_bits(8'hDE, 8, HALF, 1'b0, mi);
      n_total++;
      if (mi !== 8'h12) $display("FAIL b2b_miso_word1: got %h expected 12", mi);
      else n_pass++;
      n_total++;
      if (un_cnt != u0) $display("FAIL b2b_no_underrun: got %0d underruns expected 0", un_cnt - u0);
      else n_pass++;
      // Final falling edge and ss_n release land on the same clk edge.
      spi_bits(8'hAD, 8, HALF, 1'b1, mi);
      repeat (2) @(negedge clk);
      n_total++;
      if (mi !== 8'h34) $display("FAIL b2b_miso_word2: got %h expected 34", mi);
      else n_pass++;
      n_total++;
      if (rx_cnt != r0 + 2 || rx_hist[r0] !== 8'hDE || rx_hist[r0+1] !== 8'hAD)
         $display("FAIL b2b_rx: pulses %0d expected 2 with de,ad", rx_cnt - r0);
      else n_pass++;
      n_total++;
      if (ab_cnt != a0 || miso_oe !== 1'b0)
         $display("FAIL b2b_coincident_release: aborts %0d oe %b expected 0 and 0", ab_cnt - a0, miso_oe);
      else n_pass++;
   endtask

   task automatic test_underrun();
      logic [7:0] mi;
      int u0 = un_cnt;
      int r0 = rx_cnt;
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      n_total++;
      if (un_cnt != u0 + 1) $display("FAIL underrun_start: got %0d pulses expected 1", un_cnt - u0);
      else n_pass++;
      spi_bits(8'h69, 8, HALF, 1'b0, mi);
      n_total++;
      if (mi !== 8'hFF) $display("FAIL underrun_miso: got %h expected ff", mi);
      else n_pass++;
      n_total++;
      if (rx_cnt != r0 + 1 || rx_data !== 8'h69)
         $display("FAIL underrun_rx: pulses %0d data %h expected 1 and 69", rx_cnt - r0, rx_data);
      else n_pass++;
      // Empty buffer at the word boundary reloads DEFAULT_TX once more.
      n_total++;
      if (un_cnt != u0 + 2) $display("FAIL underrun_reload: got %0d pulses expected 2", un_cnt - u0);
      else n_pass++;
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_abort();
      logic [7:0] mi;
      int r0 = rx_cnt;
      int a0 = ab_cnt;
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'hF0, 5, HALF, 1'b0, mi);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
      n_total++;
      if (ab_cnt != a0 + 1) $display("FAIL abort_pulse: got %0d cycles expected 1", ab_cnt - a0);
      else n_pass++;
      n_total++;
      if (rx_cnt != r0 || rx_data !== 8'h69)
         $display("FAIL abort_rx_kept: pulses %0d data %h expected 0 and 69", rx_cnt - r0, rx_data);
      else n_pass++;
      n_total++;
      if ({miso_oe, miso} !== 2'b00) $display("FAIL abort_release: {oe,miso} got %b expected 00", {miso_oe, miso});
      else n_pass++;
      offer(8'h81, "post_abort");
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'h7E, 8, HALF, 1'b0, mi);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
      n_total++;
      if (mi !== 8'h81 || rx_data !== 8'h7E || rx_cnt != r0 + 1)
         $display("FAIL abort_recover: miso %h rx %h pulses %0d expected 81 7e 1", mi, rx_data, rx_cnt - r0);
      else n_pass++;
   endtask

   task automatic test_loopback();
      logic [7:0] mi;
      offer(8'hC3, "loopback");
      ss_n = 1'b0;
      repeat (4) @(negedge clk);
      spi_bits(8'h5A, 8, 4, 1'b0, mi);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
      n_total++;
      if (mi !== 8'hC3 || rx_data !== 8'h5A)
         $display("FAIL loopback: master dout %h peripheral rx %h expected c3 and 5a", mi, rx_data);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_loopback();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
